// File: rtl/pcie_bar_responder.sv
// pcie_bar_responder: BAR target executing one register access at a time with a response channel
module pcie_bar_responder #(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] DEV_ID   = 32'h1A2B_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tl_bar_vld,
    output logic        tl_bar_rdy,
    input  logic [5:0]  tl_bar_adr,
    input  logic        tl_bar_wr,
    input  logic [31:0] tl_bar_wdata,
    input  logic [3:0]  tl_bar_wstrb,
    output logic        tl_bar_rsp_vld,
    input  logic        tl_bar_rsp_rdy,
    output logic [31:0] tl_bar_rdata,
    output logic [1:0]  tl_bar_rresp,
    output logic        int_req,
    output logic [7:0]  gpios_out
);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [5:0]  adr_q, adr_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        int_q, int_d;
    logic [31:0] acc_cnt_q, acc_cnt_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic        in_range, writable;
    logic [31:0] rd_val;

    assign in_range = {1'b0, adr_q} < 7'(NUM_REGS);
    assign writable = in_range && (adr_q == 6'd1 || adr_q >= 6'd4);
    // Registers 0, 2 and 3 are never stored; their read values come from constants or the counter
    assign rd_val = !in_range      ? 32'h0 :
                    adr_q == 6'd0  ? DEV_ID :
                    adr_q == 6'd2  ? 32'h0 :
                    adr_q == 6'd3  ? acc_cnt_q :
                    regs_q[adr_q[IW-1:0]];

    assign tl_bar_rdy     = rst_n && state_q == IDLE;
    assign tl_bar_rsp_vld = state_q == RESP;
    assign tl_bar_rdata   = rdata_q;
    assign tl_bar_rresp   = rresp_q;
    assign int_req        = int_q;
    assign gpios_out      = regs_q[1][7:0];

    // Request capture, single-cycle register access and response handshake
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        acc_cnt_d = acc_cnt_q;
        regs_d    = regs_q;
        int_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tl_bar_vld) begin
                    adr_d   = tl_bar_adr;
                    wr_d    = tl_bar_wr;
                    wdata_d = tl_bar_wdata;
                    wstrb_d = tl_bar_wstrb;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = wr_q ? 32'h0 : rd_val;
                rresp_d = (!in_range || (wr_q && !writable && adr_q != 6'd2)) ? 2'b10 : 2'b00;
                int_d   = wr_q && in_range && adr_q == 6'd2 && |wstrb_q;
                if (wr_q && writable)
                    for (int i = 0; i < 4; i++)
                        if (wstrb_q[i]) regs_d[adr_q[IW-1:0]][8*i +: 8] = wdata_q[8*i +: 8];
            end
            RESP: begin
                if (tl_bar_rsp_rdy) begin
                    acc_cnt_d = acc_cnt_q + 32'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any pending response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            int_q     <= 1'b0;
            acc_cnt_q <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            int_q     <= int_d;
            acc_cnt_q <= acc_cnt_d;
            regs_q    <= regs_d;
        end
    end
endmodule
